// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - keypad debouncer feeding a first-word-fall-through key event queue
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module key_event_fifo #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DEPTH           = 4,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               key_raw,
  input  logic                     pressed_raw,
  input  logic                     pop,
  output logic [4:0]               key,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW = $clog2(DEPTH);

  if (DEBOUNCE_CYCLES < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("key_event_fifo: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE} state_t;

  state_t          state, state_nx;
  logic [4:0]      key_m, key_s, code;
  logic            pressed_m, pressed_s;
  logic [CW-1:0]   cnt;
  logic            cnt_done;
  logic            press_push, rpt_push, push;

  logic [4:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, do_push, do_pop;

  // Raw scanner outputs are asynchronous to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_m     <= '0;
      key_s     <= '0;
      pressed_m <= 1'b0;
      pressed_s <= 1'b0;
    end else begin
      key_m     <= key_raw;
      key_s     <= key_m;
      pressed_m <= pressed_raw;
      pressed_s <= pressed_m;
    end
  end

  assign cnt_done = (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:            if (pressed_s) state_nx = CONFIRM_PRESS;
      CONFIRM_PRESS:   if (!pressed_s || key_s != code) state_nx = IDLE;
                       else if (cnt_done)            state_nx = HELD;
      HELD:            if (!pressed_s) state_nx = CONFIRM_RELEASE;
      CONFIRM_RELEASE: if (pressed_s)     state_nx = HELD;
                       else if (cnt_done) state_nx = IDLE;
      default:         state_nx = IDLE;
    endcase
  end

  always_comb begin
    press_push = (state == CONFIRM_PRESS) && pressed_s && (key_s == code) && cnt_done;
    push       = press_push || rpt_push;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (pressed_s) begin
          code <= key_s;
          cnt  <= '0;
        end
        CONFIRM_PRESS:   if (pressed_s && key_s == code && !cnt_done) cnt <= cnt + 1'b1;
        HELD:            if (!pressed_s) cnt <= '0;
        CONFIRM_RELEASE: if (!pressed_s && !cnt_done) cnt <= cnt + 1'b1;
        default:         cnt <= '0;
      endcase
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  logic [RW-1:0] rpt;

  assign rpt_push = (state == HELD) && pressed_s && (rpt == RW'(REPEAT_CYCLES - 1));

  // Period restarts on every entry to HELD, including a bounce back from CONFIRM_RELEASE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      rpt <= '0;
    else if (state_nx == HELD && state != HELD)   rpt <= '0;
    else if (state == HELD)                       rpt <= rpt_push ? '0 : rpt + 1'b1;
  end
`else
  assign rpt_push = 1'b0;
`endif

  assign valid   = (count != '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = pop && valid;
  // A pop on the same edge frees the slot, so a full queue still accepts the push
  assign do_push = push && (!full || do_pop);
  assign key     = valid ? mem[rd_ptr] : 5'd0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow <= push && !do_push;
    end
  end

endmodule
